truth_table_checker: RTL and testbench
======================================

// Module: truth_table_checker
// PURPOSE
//  Self-running response checker: the capture/compare end of our exhaustive 3-input gate benches.
//  Drives every input code 0..2^N_IN-1 onto a combinational DUT and samples its 1-bit output
//  after a settle window. Compares each sample against a parameterised expected truth table.
//  Reports error count, first failing code and pass/fail; usable in simulation and on board.
// PARAMETERS
//  N_IN      3      DUT input width; codes swept 0..2^N_IN-1 (1..8)
//  EXPECTED  8'h69  expected f per code, bit i = f for code i (8'h69 = 3-input XNOR); width 2^N_IN
//  SETTLE    4      clocks dut_in is held before sampling (>=1)
// PORTS
//  clk            in   1          rising-edge clock
//  rst_n          in   1          asynchronous active-low reset
//  start          in   1          1-cycle pulse, begins a sweep; honoured in IDLE or DONE only
//  dut_in         out  N_IN       stimulus code to DUT, MSB = first DUT input (A), LSB = last (C)
//  dut_f          in   1          DUT response
//  busy           out  1          high in SETTLE/SAMPLE
//  done           out  1          high in DONE, held until next start or reset
//  pass           out  1          done && err_count==0
//  err_count      out  N_IN+1     mismatches in current/last sweep (max 2^N_IN, no wrap)
//  first_err_vld  out  1          a mismatch has been recorded this sweep
//  first_err_idx  out  N_IN       code of the first mismatch; valid when first_err_vld
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; dut_in, err_count, first_err_idx=0;
//   busy, done, pass, first_err_vld=0. Reset mid-sweep aborts immediately; no partial results kept.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//   IDLE  : start -> SETTLE; dut_in<=0, settle_cnt<=0, err_count<=0, first_err_vld<=0, first_err_idx<=0.
//   SETTLE: settle_cnt++ each clock; when settle_cnt==SETTLE-1 -> SAMPLE.
//   SAMPLE: one cycle; mismatch = dut_f != EXPECTED[dut_in].
//           mismatch: err_count++; if !first_err_vld {first_err_vld<=1; first_err_idx<=dut_in}.
//           dut_in==2^N_IN-1 -> DONE, dut_in holds; else dut_in++, settle_cnt<=0 -> SETTLE.
//   DONE  : done=1, results frozen; start -> same actions as IDLE+start (re-run).
//  dut_in changes only on the SAMPLE->SETTLE edge; stable through SETTLE+SAMPLE of each code.
//  Timing: start sampled at edge 0 -> busy from edge 0; each code occupies SETTLE+1 clocks;
//   done rises at edge 2^N_IN*(SETTLE+1) (defaults: edge 40), busy falls same edge.
//  start while busy is ignored (no restart, no effect on counters).
//  start and rst_n low together: reset wins.
//  dut_f sampled only in SAMPLE; X/glitches during SETTLE are don't-care.
//  err_count cannot overflow: N_IN+1 bits holds 2^N_IN.
//  pass and done are registered (from state/err_count), never combinational from dut_f.
// TESTING
//  1 Reset: rst_n=0 mid-sweep (e.g. code 3) -> all outputs 0 within same cycle, state IDLE.
//  2 Golden DUT (f=~(A^B^C)), defaults, start pulse -> dut_in steps 0..7 every 5 clks,
//    done at edge 40, pass=1, err_count=0, first_err_vld=0.
//  3 DUT forced f=0 -> err_count=4 (codes 0,3,5,6), first_err_idx=0, pass=0.
//  4 DUT = XOR (inverted) -> err_count=8, first_err_idx=0; second start in DONE clears and
//    re-runs to identical result.
//  5 start pulses at codes 2 and 6 while busy -> ignored; done still at edge 40.
//  6 SETTLE=1, N_IN=2, EXPECTED=4'h8 (AND), golden AND DUT -> done at edge 8, pass=1.

Source files
------------

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps every input code onto a combinational DUT.
// Each code is held for SETTLE clocks and then sampled for one clock.
// The 1-bit response is compared against the EXPECTED truth table.
// Reports mismatch count, first failing code and an overall pass flag.
module truth_table_checker #(
    parameter int unsigned              N_IN     = 3,
    parameter logic [(1 << N_IN) - 1:0] EXPECTED = 8'h69,
    parameter int unsigned              SETTLE   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_f,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            first_err_vld,
    output logic [N_IN-1:0] first_err_idx
);

    localparam int unsigned    CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] settle_cnt;
    logic          launch;
    logic          mismatch;
    logic          last_code;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode; start is only honoured from IDLE or DONE
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        mismatch   = (dut_f != EXPECTED[dut_in]);
        last_code  = &dut_in;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                next_state = last_code ? S_DONE : S_SETTLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Stimulus code, settle timer and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in        <= '0;
            settle_cnt    <= '0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else if (launch) begin
            dut_in        <= '0;
            settle_cnt    <= '0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_idx <= dut_in;
                        end
                    end
                    if (!last_code) begin
                        dut_in     <= dut_in + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags decoded from registered state and count only
    always_comb begin
        busy = (state == S_SETTLE) || (state == S_SAMPLE);
        done = (state == S_DONE);
        pass = (state == S_DONE) && (err_count == '0);
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: default 3-input XNOR checker plus a 2-input AND variant.
module tb_truth_table_checker;

    typedef struct {
        logic [3:0] errs;
        logic       vld;
        logic [2:0] idx;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] dut_in;
    logic       dut_f;
    logic       busy, done, pass;
    logic [3:0] err_count;
    logic       first_err_vld;
    logic [2:0] first_err_idx;

    logic       start2;
    logic [1:0] dut_in2;
    logic       dut_f2;
    logic       busy2, done2, pass2;
    logic [2:0] err_count2;
    logic       first_err_vld2;
    logic [1:0] first_err_idx2;

    int          mode = 0;
    int unsigned cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    exp_t        sb[$];

    truth_table_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_f(dut_f),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_vld(first_err_vld), .first_err_idx(first_err_idx)
    );

    truth_table_checker #(.N_IN(2), .EXPECTED(4'h8), .SETTLE(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(dut_in2), .dut_f(dut_f2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
        .first_err_vld(first_err_vld2), .first_err_idx(first_err_idx2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic ref_f(input logic [2:0] c);
        return ~(c[2] ^ c[1] ^ c[0]);
    endfunction

    function automatic logic model_f(input int m, input logic [2:0] c);
        case (m)
            1:       return 1'b0;
            2:       return c[2] ^ c[1] ^ c[0];
            default: return ref_f(c);
        endcase
    endfunction

    assign dut_f  = model_f(mode, dut_in);
    assign dut_f2 = dut_in2[1] & dut_in2[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input int m);
        exp_t e;
        e.errs = '0;
        e.vld  = 1'b0;
        e.idx  = '0;
        for (int i = 0; i < 8; i++) begin
            if (model_f(m, 3'(i)) != ref_f(3'(i))) begin
                if (!e.vld) begin
                    e.vld = 1'b1;
                    e.idx = 3'(i);
                end
                e.errs = e.errs + 4'd1;
            end
        end
        e.pass = (e.errs == 4'd0);
        sb.push_back(e);
    endtask

    // One full sweep with the default DUT; inject pulses start mid-sweep at codes 2 and 6
    task automatic sweep(input int m, input bit inject);
        int unsigned t0;
        int unsigned rel;
        bit          found;
        exp_t        e;
        mode = m;
        push_model(m);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        chk("busy after start", busy, 1);
        chk("done cleared on start", done, 0);
        chk("err_count cleared on start", err_count, 0);
        chk("first_err_vld cleared on start", first_err_vld, 0);
        found = 1'b0;
        for (int k = 0; k <= 200; k++) begin
            rel = cyc - t0;
            if (done) begin
                found = 1'b1;
                break;
            end
            if (rel % 5 == 0 && rel < 40) chk("dut_in step", dut_in, rel / 5);
            start = (inject && (dut_in == 3'd2 || dut_in == 3'd6) && rel % 5 == 1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("done reached", found, 1);
        chk("done edge", cyc - t0, 40);
        chk("busy at done", busy, 0);
        chk("scoreboard depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("err_count", err_count, e.errs);
            chk("first_err_vld", first_err_vld, e.vld);
            chk("first_err_idx", first_err_idx, e.idx);
            chk("pass", pass, e.pass);
        end
    endtask

    initial begin
        int unsigned t0;
        bit          found;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        #1;
        chk("reset dut_in", dut_in, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset pass", pass, 0);
        chk("reset err_count", err_count, 0);
        chk("reset first_err_vld", first_err_vld, 0);
        #12;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle after reset", busy, 0);

        // Golden XNOR DUT
        sweep(0, 1'b0);
        // Stuck-at-0 DUT
        sweep(1, 1'b0);
        // Inverted (XOR) DUT, then re-run from DONE
        sweep(2, 1'b0);
        sweep(2, 1'b0);
        // Start pulses while busy must be ignored
        sweep(1, 1'b1);

        // Asynchronous reset in the middle of a sweep
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (dut_in == 3'd3) break;
            @(posedge clk); #1;
        end
        chk("reached code 3", dut_in, 3);
        chk("errors before abort", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort dut_in", dut_in, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort err_count", err_count, 0);
        chk("abort first_err_vld", first_err_vld, 0);
        chk("abort first_err_idx", first_err_idx, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stays idle after abort", busy, 0);

        // 2-input AND variant, SETTLE=1
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        t0 = cyc;
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (done2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("small done reached", found, 1);
        chk("small done edge", cyc - t0, 8);
        chk("small pass", pass2, 1);
        chk("small err_count", err_count2, 0);
        chk("small first_err_vld", first_err_vld2, 0);
        chk("small dut_in held", dut_in2, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
